// File: rtl/timer_ctrl_pkg.sv
// Shared encodings for the interval-timer controller.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;
    localparam logic ONESHOT  = 1'b0;
    localparam logic PERIODIC = 1'b1;

    function automatic logic is_busy(state_e s);
        return (s == ARM) || (s == RUN);
    endfunction

endpackage

// File: rtl/timer_ctrl_tick_prescaler.sv
// Free-running divider: tick_o is high while the count equals limit_i, count wraps on tick.
module tick_prescaler #(
    parameter int PW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic [PW-1:0] limit_i,
    output logic          tick_o
);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (clr_i || tick_o)
            cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/timer_ctrl.sv
// Interval-timer sequencer driving an external loadable up/down counter.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          periodic,
    input  logic          dir_up,
    input  logic [N-1:0]  period,
    input  logic [PW-1:0] prescale,
    input  logic          irq_ack,
    output logic          cnt_clr,
    output logic          cnt_load,
    output logic          cnt_en,
    output logic          cnt_up,
    output logic [N-1:0]  cnt_d,
    input  logic [N-1:0]  cnt_q,
    output logic          busy,
    output logic          done,
    output logic          irq,
    output logic          ovf
);

    state_e        state_q, state_d;
    logic          periodic_q, periodic_d;
    logic          dir_up_q, dir_up_d;
    logic [N-1:0]  period_q, period_d;
    logic [PW-1:0] prescale_q, prescale_d;
    logic          irq_q, irq_d;
    logic          ovf_q, ovf_d;

    logic accept, tick_raw, tick, term, hit;

    // stop beats start, so a simultaneous pair never re-arms
    assign accept = start && !stop;

    tick_prescaler #(.PW(PW)) u_presc (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (state_q != RUN),
        .limit_i (prescale_q),
        .tick_o  (tick_raw)
    );

    assign tick = (state_q == RUN) && tick_raw;
    assign term = (dir_up_q == DIR_UP) ? (cnt_q == period_q) : (cnt_q == '0);
    assign hit  = tick && term;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            periodic_q <= 1'b0;
            dir_up_q   <= 1'b0;
            period_q   <= '0;
            prescale_q <= '0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            periodic_q <= periodic_d;
            dir_up_q   <= dir_up_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            irq_q      <= irq_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        periodic_d = periodic_q;
        dir_up_d   = dir_up_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        if (accept) begin
            periodic_d = periodic;
            dir_up_d   = dir_up;
            period_d   = period;
            prescale_d = prescale;
        end
        unique case (state_q)
            IDLE: if (accept) state_d = ARM;
            ARM: begin
                if (stop)       state_d = IDLE;
                else if (start) state_d = ARM;
                else            state_d = RUN;
            end
            RUN: begin
                if (stop)                             state_d = IDLE;
                else if (start)                       state_d = ARM;
                else if (hit && periodic_q == ONESHOT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        done     = 1'b0;
        busy     = is_busy(state_q);
        unique case (state_q)
            ARM: begin
                if (!stop) begin
                    cnt_clr  = (dir_up_q == DIR_UP);
                    cnt_load = (dir_up_q == DIR_DOWN);
                end
            end
            RUN: begin
                done = hit;
                // periodic reload happens in the terminal cycle itself
                if (!stop) begin
                    cnt_en   = tick && !term;
                    cnt_clr  = hit && periodic_q == PERIODIC && dir_up_q == DIR_UP;
                    cnt_load = hit && periodic_q == PERIODIC && dir_up_q == DIR_DOWN;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        irq_d = done || (irq_q && !irq_ack);
        ovf_d = !irq_ack && (ovf_q || (done && irq_q));
    end

    assign cnt_up = dir_up_q;
    assign cnt_d  = period_q;
    assign irq    = irq_q;
    assign ovf    = ovf_q;

endmodule
